// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: read side of a 2bpp 320x240 framebuffer, pixel-doubled onto 640x480@60 VGA.
// Latency: one pixel tick (CLK_DIV clocks) from counter position to the pins.
// No backpressure: this block owns the RAM read port, which must answer within CLK_DIV clocks.
module vga_fb_scanout #(
  parameter int          CLK_DIV      = 2,
  parameter logic [11:0] COLOR_P1     = 12'hF80,
  parameter logic [11:0] COLOR_P2     = 12'h08F,
  parameter logic [11:0] COLOR_BORDER = 12'hFFF,
  // Raster geometry; defaults are standard 640x480@60 timing.
  parameter int          H_VISIBLE    = 640,
  parameter int          H_FRONT      = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 48,
  parameter int          V_VISIBLE    = 480,
  parameter int          V_FRONT      = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 33
) (
  input  logic        clock,
  input  logic        reset,
  output logic [18:0] ram_address,
  input  logic [1:0]  ram_read_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // One framebuffer row holds half as many cells as there are visible pixels.
  localparam logic [18:0] ROW_CELLS = 19'(H_VISIBLE / 2);

  logic [DIV_W-1:0] divider;
  logic             tick;
  logic [9:0]       hcount;
  logic [9:0]       vcount;
  logic [9:0]       hcount_next;
  logic [9:0]       vcount_next;
  logic             h_wrap;
  logic             frame_wrap;
  logic             next_visible;
  logic             next_in_hsync;
  logic             next_in_vsync;
  logic [18:0]      next_address;

  // Stage-0 flags describe the position the counters currently hold.
  logic             s0_visible;
  logic             s0_in_hsync;
  logic             s0_in_vsync;

  function automatic logic [11:0] palette(input logic [1:0] code);
    case (code)
      2'b01:   return COLOR_P1;
      2'b10:   return COLOR_P2;
      2'b11:   return COLOR_BORDER;
      default: return 12'h000;
    endcase
  endfunction

  // Pixel tick, and the position the counters will enter on that tick.
  always_comb begin
    tick          = (divider == DIV_LAST);
    h_wrap        = (hcount == H_LAST);
    frame_wrap    = h_wrap && (vcount == V_LAST);
    hcount_next   = h_wrap ? 10'd0 : hcount + 10'd1;
    vcount_next   = vcount;
    if (h_wrap) begin
      vcount_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end
    next_visible  = (hcount_next < H_VIS) && (vcount_next < V_VIS);
    next_in_hsync = (hcount_next >= H_SYNC_LO) && (hcount_next < H_SYNC_END);
    next_in_vsync = (vcount_next >= V_SYNC_LO) && (vcount_next < V_SYNC_END);
    next_address  = 19'(vcount_next[9:1]) * ROW_CELLS + 19'(hcount_next[9:1]);
  end

  // Clock divider producing one tick every CLK_DIV clocks.
  always_ff @(posedge clock) begin
    if (reset || tick) begin
      divider <= '0;
    end else begin
      divider <= divider + 1'b1;
    end
  end

  // Raster position counters, advanced once per tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      hcount <= hcount_next;
      vcount <= vcount_next;
    end
  end

  // Stage 0: issue the read address and capture blanking/sync flags for the entered position.
  // Reset leaves stage 0 describing pixel (0,0), so the first tick after reset shows it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_address <= '0;
      s0_visible  <= 1'b1;
      s0_in_hsync <= 1'b0;
      s0_in_vsync <= 1'b0;
    end else if (tick) begin
      s0_visible  <= next_visible;
      s0_in_hsync <= next_in_hsync;
      s0_in_vsync <= next_in_vsync;
      if (next_visible) begin
        ram_address <= next_address;
      end
    end
  end

  // Stage 1: colour lookup plus syncs, all delayed by the same tick so they stay aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hsync             <= 1'b1;
      vga_vsync             <= 1'b1;
    end else if (tick) begin
      {vga_r, vga_g, vga_b} <= s0_visible ? palette(ram_read_data) : 12'h000;
      vga_hsync             <= ~s0_in_hsync;
      vga_vsync             <= ~s0_in_vsync;
    end
  end

  // Frame tick: one clock, coincident with the address of pixel (0,0) being issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: three instances (CLK_DIV=2 with random RAM, CLK_DIV=4 with
// address-pattern RAM, short-frame CLK_DIV=2 with all-border RAM) checked every clock
// against a time-based raster model, plus address vectors and pulse-width measurements.
module tb_vga_fb_scanout;

  localparam int          H_TOT = 800;
  localparam logic [11:0] C_P1  = 12'hF80;
  localparam logic [11:0] C_P2  = 12'h08F;
  localparam logic [11:0] C_BD  = 12'hFFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  logic [18:0] addr_a, addr_4, addr_v;
  logic [1:0]  data_a, data_4, data_v;
  logic [3:0]  r_a, g_a, b_a, r_4, g_4, b_4, r_v, g_v, b_v;
  logic        hs_a, vs_a, fs_a, hs_4, vs_4, fs_4, hs_v, vs_v, fs_v;

  vga_fb_scanout #(.CLK_DIV(2)) dut_a (
    .clock(clock), .reset(reset_a), .ram_address(addr_a), .ram_read_data(data_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
    .frame_start(fs_a));

  vga_fb_scanout #(.CLK_DIV(4)) dut_4 (
    .clock(clock), .reset(reset_b), .ram_address(addr_4), .ram_read_data(data_4),
    .vga_r(r_4), .vga_g(g_4), .vga_b(b_4), .vga_hsync(hs_4), .vga_vsync(vs_4),
    .frame_start(fs_4));

  vga_fb_scanout #(.CLK_DIV(2), .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_v (
    .clock(clock), .reset(reset_b), .ram_address(addr_v), .ram_read_data(data_v),
    .vga_r(r_v), .vga_g(g_v), .vga_b(b_v), .vga_hsync(hs_v), .vga_vsync(vs_v),
    .frame_start(fs_v));

  // Framebuffer contents for instance A, randomised at start.
  logic [1:0] mem [76800];

  function automatic logic [1:0] mem_rd(input logic [18:0] a);
    if (a < 19'd76800) return mem[int'(a)];
    return 2'b00;
  endfunction

  // RAM models: one clock read latency.
  always @(posedge clock) begin
    data_a <= mem_rd(addr_a);
    data_4 <= addr_4[1:0];
    data_v <= 2'b11;
  end

  // Clocks elapsed since the last reset edge of each instance.
  int cyc = 0;
  int n_a = 0;
  int n_4 = 0;
  int n_v = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    n_a <= reset_a ? 0 : n_a + 1;
    n_4 <= reset_b ? 0 : n_4 + 1;
    n_v <= reset_b ? 0 : n_v + 1;
  end

  int compared   = 0;
  int mismatched = 0;
  int fail_lines = 0;
  bit mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input int n);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (fail_lines < 40) $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
      fail_lines++;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  function automatic logic [11:0] pal(input logic [1:0] c);
    case (c)
      2'b01:   return C_P1;
      2'b10:   return C_P2;
      2'b11:   return C_BD;
      default: return 12'h000;
    endcase
  endfunction

  // Address last issued when the raster stands at (h,v): the cell under a visible pixel,
  // otherwise the last visible cell passed.
  function automatic logic [18:0] addr_of(input int h, input int v, input int vvis);
    if (v < vvis) return 19'(320 * (v / 2) + ((h < 640) ? h / 2 : 319));
    return 19'(320 * ((vvis - 1) / 2) + 319);
  endfunction

  function automatic logic [1:0] ram_code(input int src, input logic [18:0] a);
    if (src == 0) return mem_rd(a);
    if (src == 1) return a[1:0];
    return 2'b11;
  endfunction

  // Expected pins n clocks after reset: the raster sits at tick t = n/cdiv; the pins show
  // the pixel one tick behind it.
  function automatic exp_t model(input int n, input int cdiv, input int vvis, input int vfront,
                                 input int vsw, input int vtot, input int src);
    exp_t e;
    int t, p, h, v, q, hq, vq;
    t      = n / cdiv;
    p      = t % (H_TOT * vtot);
    h      = p % H_TOT;
    v      = p / H_TOT;
    e.addr = addr_of(h, v, vvis);
    e.fs   = (n > 0) && (n % cdiv == 0) && (p == 0);
    if (t == 0) begin
      e.rgb = 12'h000;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
    end else begin
      q     = (t - 1) % (H_TOT * vtot);
      hq    = q % H_TOT;
      vq    = q / H_TOT;
      e.rgb = (hq < 640 && vq < vvis) ? pal(ram_code(src, addr_of(hq, vq, vvis))) : 12'h000;
      e.hs  = !(hq >= 656 && hq <= 751);
      e.vs  = !(vq >= vvis + vfront && vq < vvis + vfront + vsw);
    end
    return e;
  endfunction

  // ---------------- per-clock comparison against the model ----------------
  exp_t        ea, e4, ev;
  logic [32:0] prev4 = {19'd0, 12'h000, 1'b1, 1'b1};

  always @(negedge clock) begin
    if (mon_en) begin
      ea = model(n_a, 2, 480, 10, 2, 525, 0);
      check("a_addr",   32'(addr_a), 32'(ea.addr), n_a);
      check("a_rgb",    32'({r_a, g_a, b_a}), 32'(ea.rgb), n_a);
      check("a_hsync",  32'(hs_a), 32'(ea.hs), n_a);
      check("a_vsync",  32'(vs_a), 32'(ea.vs), n_a);
      check("a_fstart", 32'(fs_a), 32'(ea.fs), n_a);

      e4 = model(n_4, 4, 480, 10, 2, 525, 1);
      check("d4_addr",  32'(addr_4), 32'(e4.addr), n_4);
      check("d4_rgb",   32'({r_4, g_4, b_4}), 32'(e4.rgb), n_4);
      check("d4_hsync", 32'(hs_4), 32'(e4.hs), n_4);
      check("d4_vsync", 32'(vs_4), 32'(e4.vs), n_4);
      check("d4_fstart", 32'(fs_4), 32'(e4.fs), n_4);
      if ({addr_4, r_4, g_4, b_4, hs_4, vs_4} !== prev4)
        check("d4_change_off_tick", n_4 % 4, 0, n_4);
      prev4 = {addr_4, r_4, g_4, b_4, hs_4, vs_4};

      ev = model(n_v, 2, 8, 2, 2, 15, 2);
      check("v_addr",   32'(addr_v), 32'(ev.addr), n_v);
      check("v_rgb",    32'({r_v, g_v, b_v}), 32'(ev.rgb), n_v);
      check("v_hsync",  32'(hs_v), 32'(ev.hs), n_v);
      check("v_vsync",  32'(vs_v), 32'(ev.vs), n_v);
      check("v_fstart", 32'(fs_v), 32'(ev.fs), n_v);
    end
  end

  // ---------------- pulse width / period measurements ----------------
  logic prev_hs_a = 1'b1, prev_hs_4 = 1'b1, prev_vs_v = 1'b1;
  int   fall_a = -1, fall_4 = -1, fall_v = -1, last_fs_v = -1;
  bit   rst_since_a = 1'b0;
  int   cnt_a = 0, cnt_4 = 0, cnt_v = 0, cnt_fs = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (reset_a) rst_since_a = 1'b1;
      if (prev_hs_a && !hs_a) begin
        if (fall_a >= 0 && !rst_since_a) check("a_hsync_period", cyc - fall_a, 1600, n_a);
        fall_a      = cyc;
        rst_since_a = 1'b0;
      end
      if (!prev_hs_a && hs_a && fall_a >= 0 && !rst_since_a) begin
        check("a_hsync_low_width", cyc - fall_a, 192, n_a);
        cnt_a++;
      end
      prev_hs_a = hs_a;

      if (prev_hs_4 && !hs_4) begin
        if (fall_4 >= 0) check("d4_hsync_period", cyc - fall_4, 3200, n_4);
        fall_4 = cyc;
      end
      if (!prev_hs_4 && hs_4 && fall_4 >= 0) begin
        check("d4_hsync_low_width", cyc - fall_4, 384, n_4);
        cnt_4++;
      end
      prev_hs_4 = hs_4;

      if (prev_vs_v && !vs_v) begin
        if (fall_v >= 0) check("v_vsync_period", cyc - fall_v, 24000, n_v);
        fall_v = cyc;
      end
      if (!prev_vs_v && vs_v && fall_v >= 0) begin
        check("v_vsync_low_width", cyc - fall_v, 3200, n_v);
        cnt_v++;
      end
      prev_vs_v = vs_v;

      if (fs_v) begin
        if (last_fs_v < 0) check("v_first_frame_start", n_v, 24000, n_v);
        else               check("v_frame_start_period", cyc - last_fs_v, 24000, n_v);
        last_fs_v = cyc;
        cnt_fs++;
      end
    end
  end

  // ---------------- address vectors at chosen raster positions ----------------
  typedef struct {
    int          h;
    int          v;
    logic [18:0] addr;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{0,   0,  19'd0};
    tbl[1]  = '{1,   0,  19'd0};
    tbl[2]  = '{2,   0,  19'd1};
    tbl[3]  = '{639, 1,  19'd319};
    tbl[4]  = '{640, 1,  19'd319};
    tbl[5]  = '{799, 1,  19'd319};
    tbl[6]  = '{0,   2,  19'd320};
    tbl[7]  = '{5,   2,  19'd322};
    tbl[8]  = '{638, 3,  19'd639};
    tbl[9]  = '{3,   5,  19'd641};
    tbl[10] = '{100, 10, 19'd1650};
    tbl[11] = '{639, 19, 19'd3199};
    tbl[12] = '{0,   20, 19'd3200};
    tbl[13] = '{700, 20, 19'd3519};

    for (int i = 0; i < 76800; i++) mem[i] = 2'($urandom);

    // Reset takes effect on the first edge it is seen.
    @(posedge clock);
    #2;
    check("rst_addr",   32'(addr_a), 0, n_a);
    check("rst_rgb",    32'({r_a, g_a, b_a}), 0, n_a);
    check("rst_hsync",  32'(hs_a), 1, n_a);
    check("rst_vsync",  32'(vs_a), 1, n_a);
    check("rst_fstart", 32'(fs_a), 0, n_a);
    mon_en = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset_a = 1'b0;
    reset_b = 1'b0;

    for (int i = 0; i < 14; i++) begin
      while (n_a < (tbl[i].v * H_TOT + tbl[i].h) * 2 && cyc < 90000) @(negedge clock);
      check($sformatf("addr_vec_%0d_%0d", tbl[i].h, tbl[i].v), 32'(addr_a), 32'(tbl[i].addr), n_a);
    end

    // Raster now at (700,20), inside horizontal sync: one-clock reset.
    @(posedge clock);
    #2;
    reset_a = 1'b1;
    @(posedge clock);
    #2;
    check("midrst_hsync", 32'(hs_a), 1, n_a);
    check("midrst_vsync", 32'(vs_a), 1, n_a);
    check("midrst_rgb",   32'({r_a, g_a, b_a}), 0, n_a);
    check("midrst_addr",  32'(addr_a), 0, n_a);
    reset_a = 1'b0;

    while (n_v < 50000 && cyc < 90000) @(negedge clock);
    check("run_within_budget", 32'(cyc < 90000), 1, cyc);
    check("a_hsync_pulses_seen",  32'(cnt_a >= 20), 1, cnt_a);
    check("d4_hsync_pulses_seen", 32'(cnt_4 >= 10), 1, cnt_4);
    check("v_vsync_pulses_seen",  32'(cnt_v >= 2), 1, cnt_v);
    check("v_frame_starts_seen",  32'(cnt_fs >= 2), 1, cnt_fs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #950000;
    compared++;
    mismatched++;
    $display("FAIL watchdog: reached cycle %0d, required finish before 95000", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
